ps2_receiver: RTL
=================

PS2_RECEIVER -- requirements
Module: ps2_receiver

Interface
REQ-001 SHALL have parameter FILTER_LEN, default 4, meaning consecutive equal samples of ps2_clk_d required to accept a new clock level (range 2..15).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 50000, meaning idle clk cycles mid-frame before abort (1 ms at 50 MHz).
REQ-003 SHALL have port clk  input  1  system clock; the only clock, all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port ps2_clk_d  input  1  registered PS/2 clock sample from the pad driver.
REQ-006 SHALL have port ps2_data_d  input  1  registered PS/2 data sample from the pad driver.
REQ-007 SHALL have port ps2_clk_q  output  1  1 = pad driver pulls PS/2 clock low.
REQ-008 SHALL have port ps2_data_q  output  1  1 = pad driver pulls PS/2 data low; tied 0 in this block.
REQ-009 SHALL have port host_inhibit  input  1  1 = hold device off the bus.
REQ-010 SHALL have port rx_data  output  8  last accepted scan byte.
REQ-011 SHALL have port rx_valid  output  1  rx_data holds an unacknowledged byte.
REQ-012 SHALL have port rx_ack  input  1  consumer accepts rx_data.
REQ-013 SHALL have port rx_error  output  1  one-cycle pulse on parity, framing or timeout error.
REQ-014 SHALL have port rx_overflow  output  1  one-cycle pulse when a good frame is dropped.

Function
REQ-015 SHALL filter ps2_clk_d: filtered clock (reset 1) changes only after FILTER_LEN consecutive samples at the opposite level; shorter pulses are ignored.
REQ-016 SHALL produce a one-cycle fall strobe the cycle after the filtered clock goes 1->0; ps2_data_d is sampled on that strobe.
REQ-017 SHALL implement states IDLE, DATA, PARITY, STOP.
REQ-018 IDLE: strobe with data=0 -> DATA, bit count 0; strobe with data=1 -> stay IDLE, no error.
REQ-019 DATA: shift data in LSB first; after the 8th bit -> PARITY.
REQ-020 PARITY: record sampled bit -> STOP.
REQ-021 STOP: on strobe -> IDLE; frame good when data bits plus parity have odd count of ones and stop bit = 1.
REQ-022 Good frame: in the cycle after the stop strobe, rx_data loads the byte and rx_valid rises, unless rx_valid is high and rx_ack is low that cycle.
REQ-023 Dropped frame: in that case rx_data and rx_valid are unchanged and rx_overflow pulses.
REQ-024 Bad frame: rx_error pulses in the cycle after the stop strobe; rx_data and rx_valid are unchanged.
REQ-025 rx_valid SHALL stay high until a cycle with rx_ack=1, then clear next cycle; rx_ack while rx_valid=0 is ignored.
REQ-026 Good frame completing in the same cycle as rx_ack: the new byte loads, rx_valid stays 1, no overflow.
REQ-027 ps2_clk_q SHALL be a registered copy of host_inhibit.
REQ-028 While host_inhibit=1: state forced to IDLE, bit count cleared, strobes ignored, no error reported; held rx_data and rx_valid are kept.

Reset
REQ-029 On rst: state IDLE, bit count 0, filtered clock 1, filter counter 0, rx_data 0x00, rx_valid 0, rx_error 0, rx_overflow 0, ps2_clk_q 0, ps2_data_q 0.
REQ-030 rst mid-frame SHALL discard the partial frame with no error pulse; reception resumes at the next start bit after release.

Configuration
REQ-031 With macro PS2_RX_TIMEOUT_EN defined: in non-IDLE states a counter clears on each strobe; reaching TIMEOUT_CYCLES forces IDLE and pulses rx_error.
REQ-032 Without PS2_RX_TIMEOUT_EN: no timeout counter; a partial frame waits indefinitely until further strobes, host_inhibit or rst; TIMEOUT_CYCLES is unused.

Verification
REQ-033 Frame 0x1C (bits 0,0,1,1,1,0,0,0; parity 0; stop 1) -> rx_data=0x1C, rx_valid=1 the cycle after the stop strobe; rx_ack -> rx_valid=0 next cycle.
REQ-034 0x1C with parity 1 -> one rx_error pulse; rx_valid stays 0; a following 0xF0 (parity 1) -> rx_data=0xF0.
REQ-035 0xAA then 0x55, no rx_ack -> rx_data=0xAA, rx_valid=1, one rx_overflow pulse on the second frame.
REQ-036 ps2_clk_d low for FILTER_LEN-1 cycles during IDLE -> no strobe, state stays IDLE; low for FILTER_LEN cycles -> one strobe.
REQ-037 PS2_RX_TIMEOUT_EN: stop after 4 data bits, wait TIMEOUT_CYCLES -> rx_error pulse, IDLE; next frame 0x1C received correctly.
REQ-038 host_inhibit=1 mid-frame -> ps2_clk_q=1 next cycle, no rx_error; release, then frame 0x29 -> rx_data=0x29.

Source files
------------

// File: rtl/ps2_receiver.sv
// PS/2 device-to-host frame receiver: clock glitch filter, frame FSM and one-byte holding register.
// Optional mid-frame inactivity timeout is built when PS2_RX_TIMEOUT_EN is defined.
module ps2_receiver #(
    parameter int unsigned FILTER_LEN     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk_d,
    input  logic       ps2_data_d,
    output logic       ps2_clk_q,
    output logic       ps2_data_q,
    input  logic       host_inhibit,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ack,
    output logic       rx_error,
    output logic       rx_overflow
);

    localparam int unsigned FCNT_W = 4;
    localparam int unsigned BCNT_W = 3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // Reject out-of-range parameters at elaboration
    if (FILTER_LEN < 2 || FILTER_LEN > 15 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("ps2_receiver: FILTER_LEN must be 2..15 and TIMEOUT_CYCLES >= 1");
    end

    logic              filt_clk;
    logic [FCNT_W-1:0] filt_cnt;
    logic              filt_fall_c;
    logic              fall_stb;

    state_t            state;
    state_t            state_nxt;
    logic [BCNT_W-1:0] bit_cnt;
    logic [BCNT_W-1:0] bit_cnt_nxt;
    logic [7:0]        shift;
    logic [7:0]        shift_nxt;
    logic              par_bit;
    logic              par_bit_nxt;
    logic [7:0]        rx_data_nxt;
    logic              rx_valid_nxt;
    logic              rx_error_nxt;
    logic              rx_overflow_nxt;
    logic              frame_good_c;

`ifdef PS2_RX_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0]   to_cnt;
    logic [TO_W-1:0]   to_cnt_nxt;
`endif

    // The filtered level flips on the FILTER_LEN-th consecutive opposite sample
    assign filt_fall_c = filt_clk && !ps2_clk_d && (filt_cnt == FCNT_W'(FILTER_LEN - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt_clk <= 1'b1;
            filt_cnt <= '0;
            fall_stb <= 1'b0;
        end else begin
            fall_stb <= filt_fall_c;
            if (ps2_clk_d == filt_clk) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FCNT_W'(FILTER_LEN - 1)) begin
                filt_clk <= ps2_clk_d;
                filt_cnt <= '0;
            end else begin
                filt_cnt <= filt_cnt + FCNT_W'(1);
            end
        end
    end

    // Odd parity over data+parity, and the stop bit currently on the line must be 1
    assign frame_good_c = (^{shift, par_bit}) && ps2_data_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            bit_cnt     <= '0;
            shift       <= '0;
            par_bit     <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            rx_error    <= 1'b0;
            rx_overflow <= 1'b0;
            ps2_clk_q   <= 1'b0;
`ifdef PS2_RX_TIMEOUT_EN
            to_cnt      <= '0;
`endif
        end else begin
            state       <= state_nxt;
            bit_cnt     <= bit_cnt_nxt;
            shift       <= shift_nxt;
            par_bit     <= par_bit_nxt;
            rx_data     <= rx_data_nxt;
            rx_valid    <= rx_valid_nxt;
            rx_error    <= rx_error_nxt;
            rx_overflow <= rx_overflow_nxt;
            ps2_clk_q   <= host_inhibit;
`ifdef PS2_RX_TIMEOUT_EN
            to_cnt      <= to_cnt_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt       = state;
        bit_cnt_nxt     = bit_cnt;
        shift_nxt       = shift;
        par_bit_nxt     = par_bit;
        rx_data_nxt     = rx_data;
        rx_valid_nxt    = rx_valid && !rx_ack;
        rx_error_nxt    = 1'b0;
        rx_overflow_nxt = 1'b0;
`ifdef PS2_RX_TIMEOUT_EN
        to_cnt_nxt      = to_cnt;
`endif

        if (host_inhibit) begin
            state_nxt   = S_IDLE;
            bit_cnt_nxt = '0;
`ifdef PS2_RX_TIMEOUT_EN
            to_cnt_nxt  = '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (fall_stb && !ps2_data_d) begin
                        state_nxt   = S_DATA;
                        bit_cnt_nxt = '0;
                    end
                end
                S_DATA: begin
                    if (fall_stb) begin
                        shift_nxt = {ps2_data_d, shift[7:1]};
                        if (bit_cnt == BCNT_W'(7)) begin
                            state_nxt   = S_PARITY;
                            bit_cnt_nxt = '0;
                        end else begin
                            bit_cnt_nxt = bit_cnt + BCNT_W'(1);
                        end
                    end
                end
                S_PARITY: begin
                    if (fall_stb) begin
                        par_bit_nxt = ps2_data_d;
                        state_nxt   = S_STOP;
                    end
                end
                S_STOP: begin
                    if (fall_stb) begin
                        state_nxt = S_IDLE;
                        if (!frame_good_c) begin
                            rx_error_nxt = 1'b1;
                        end else if (rx_valid && !rx_ack) begin
                            rx_overflow_nxt = 1'b1;
                        end else begin
                            rx_data_nxt  = shift;
                            rx_valid_nxt = 1'b1;
                        end
                    end
                end
                default: begin
                    state_nxt   = S_IDLE;
                    bit_cnt_nxt = '0;
                end
            endcase

`ifdef PS2_RX_TIMEOUT_EN
            // Abort a frame whose clock has gone quiet; a strobe always restarts the count
            if (state == S_IDLE || fall_stb) begin
                to_cnt_nxt = '0;
            end else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                to_cnt_nxt   = '0;
                state_nxt    = S_IDLE;
                bit_cnt_nxt  = '0;
                rx_error_nxt = 1'b1;
            end else begin
                to_cnt_nxt = to_cnt + TO_W'(1);
            end
`endif
        end
    end

    assign ps2_data_q = 1'b0;

endmodule
